stopwatch_bcd_counter_cgrundey: RTL and testbench
=================================================

# stopwatch_bcd_counter_cgrundey

Minutes:seconds stopwatch core that produces four BCD digits (MM:SS). Each digit feeds one per-digit seven-segment display driver, which converts it to an active-low segment pattern. The block owns the 1 Hz prescaler, button synchronisation and edge detection, the run/pause/clear state machine, and the cascaded BCD count.

## Interface
- TICKS_PER_SEC, default 50000000: clk cycles per counted second. Must be ≥ 2.
- TICK_W, default 26: prescaler width. Must satisfy 2^TICK_W ≥ TICKS_PER_SEC.
- clk  in  1  system clock. All logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_stop  in  1  raw level from the button. A rising edge toggles run/pause.
- clear  in  1  raw level. A rising edge returns the block to zero and IDLE.
- lap  in  1  raw level. A rising edge toggles the display hold. Used only with LAP_HOLD_EN.
- sec_ones  out  4  seconds units, BCD 0–9.
- sec_tens  out  4  seconds tens, BCD 0–5.
- min_ones  out  4  minutes units, BCD 0–9.
- min_tens  out  4  minutes tens, BCD 0–5.
- running  out  1  high while in RUN.
- sec_pulse  out  1  one-cycle strobe, high in the cycle the live count shows a new value.

## Operation
- Synchronisation: each of start_stop, clear and lap passes through a 2-flop synchroniser followed by a previous-value register.
  - edge = sync2 & ~prev.
- States: IDLE, RUN, PAUSE.
  - IDLE: count = 00:00 and prescaler = 0. start edge → RUN.
  - RUN: the prescaler increments every cycle.
    - When the prescaler equals TICKS_PER_SEC-1, it returns to 0 and the BCD count increments on the same edge.
    - start edge → PAUSE.
  - PAUSE: the prescaler and count hold. start edge → RUN, and the prescaler resumes from its held value, so there is no phase loss.
- clear edge in any state → IDLE, with count, prescaler and hold flag zeroed.
  - clear has priority over start and lap edges in the same cycle.
- BCD cascade:
  - sec_ones 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into min_ones.
  - min_ones 9→0 carries into min_tens.
  - min_tens 5→0 wraps, so 59:59 → 00:00. The block stays in RUN and there is no overflow flag.
- Digits never take values outside their stated BCD ranges.
- A start edge that coincides with the prescaler terminal cycle:
  - the increment on that edge is still taken;
  - the transition to PAUSE happens on the same edge.

## Timing
- Reset (asynchronous) forces:
  - all four digits = 0, running = 0, sec_pulse = 0;
  - state = IDLE, prescaler = 0, hold flag = 0;
  - all synchroniser and previous-value flops = 0.
- Reset released mid-count restarts from IDLE. No partial count survives.
- Input latency: a level that rises before clk edge k is acted on at edge k+2.
  - running rises after edge k+2.
  - A level held high produces exactly one edge.
- sec_pulse is registered. It is high for the one cycle immediately after the incrementing edge, aligned with the new live digit values.
- Digit outputs are registered and change only on a clk edge, or asynchronously on reset.

## Configuration
- LAP_HOLD_EN defined:
  - A lap edge in RUN with the hold flag clear sets the hold flag and snapshots the live count into output registers.
  - While the flag is set, the digit outputs show the snapshot and the internal count keeps running.
  - A second lap edge clears the flag, and the outputs return to the live count on the next cycle.
  - Lap edges in IDLE or PAUSE are ignored.
  - clear releases the hold.
  - sec_pulse always tracks the live count.
- LAP_HOLD_EN undefined: the lap port exists but is ignored, and the digit outputs always show the live count.

## Test plan
All scenarios use TICKS_PER_SEC=4.
- Reset: assert rst mid-count at 00:07 → all digits 0, running 0 and sec_pulse 0 within the same cycle, without waiting for a clk edge; after release the block stays in IDLE.
- Count: start pulse, then 40 cycles → ten sec_pulse strobes, exactly 4 cycles apart, and the outputs show 00:10 (sec_tens=1, sec_ones=0).
- Wrap: force or run the count to 59:59 → the next tick gives 00:00, running stays 1, and sec_pulse fires once.
- Pause phase: start, run to prescaler=2, pause for 20 cycles, then resume → the next increment occurs exactly 2 cycles after running re-asserts, and the count is unchanged during the pause.
- Priority: clear and start rising in the same cycle while in RUN at 00:03 → IDLE, 00:00, running 0.
- Lap (LAP_HOLD_EN defined): lap edge at 00:05, run 12 cycles → outputs still show 00:05; second lap edge → outputs show 00:08 on the next cycle. With LAP_HOLD_EN undefined, the same stimulus gives outputs that track live (00:08).

Source files
------------

// File: rtl/stopwatch_bcd_counter_cgrundey.sv
// MM:SS stopwatch core: 1 Hz prescaler, button synchronisers with rising-edge
// detect, IDLE/RUN/PAUSE control and a cascaded four-digit BCD count.
// Optional feature macro: LAP_HOLD_EN (lap edge freezes the digit outputs
// while the live count keeps running; a second lap edge releases them).
module stopwatch_bcd_counter_cgrundey #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int TICK_W        = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       sec_pulse
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [TICK_W-1:0] TERM = TICK_W'(TICKS_PER_SEC - 1);

  // Button bits: [0] start_stop, [1] clear, [2] lap
  logic [2:0]        sync1_q, sync1_d;
  logic [2:0]        sync2_q, sync2_d;
  logic [2:0]        prev_q,  prev_d;
  logic [2:0]        btn_edge;

  state_t            state_q, state_d;
  logic [TICK_W-1:0] presc_q, presc_d;
  logic [15:0]       cnt_q,   cnt_d;     // {min_tens, min_ones, sec_tens, sec_ones}
  logic              pulse_q, pulse_d;

  logic              start_edge;
  logic              clr_edge;

  // One BCD digit step: returns {carry_out, next_digit}
  function automatic logic [4:0] dig_step(input logic [3:0] d,
                                          input logic [3:0] maxv,
                                          input logic       cin);
    logic [4:0] r;
    if (!cin)            r = {1'b0, d};
    else if (d >= maxv)  r = {1'b1, 4'd0};
    else                 r = {1'b0, d + 4'd1};
    return r;
  endfunction

  // Full MM:SS increment; 59:59 wraps to 00:00
  function automatic logic [15:0] bcd_inc(input logic [15:0] c);
    logic [4:0] s0, s1, s2;
    logic [3:0] mt;
    s0 = dig_step(c[3:0],  4'd9, 1'b1);
    s1 = dig_step(c[7:4],  4'd5, s0[4]);
    s2 = dig_step(c[11:8], 4'd9, s1[4]);
    if (!s2[4])               mt = c[15:12];
    else if (c[15:12] >= 4'd5) mt = 4'd0;
    else                      mt = c[15:12] + 4'd1;
    return {mt, s2[3:0], s1[3:0], s0[3:0]};
  endfunction

  assign btn_edge   = sync2_q & ~prev_q;
  assign start_edge = btn_edge[0];
  assign clr_edge   = btn_edge[1];

  // Synchroniser and previous-value chain for the three buttons
  always_comb begin
    sync1_d = {lap, clear, start_stop};
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Button pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Control FSM, prescaler and BCD count; clear overrides everything
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (clr_edge) begin
      state_d = S_IDLE;
      presc_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          presc_d = '0;
          cnt_d   = '0;
          if (start_edge) state_d = S_RUN;
        end
        S_RUN: begin
          // A start edge on the terminal cycle still takes the increment
          if (presc_q == TERM) begin
            presc_d = '0;
            cnt_d   = bcd_inc(cnt_q);
            pulse_d = 1'b1;
          end else begin
            presc_d = presc_q + TICK_W'(1);
          end
          if (start_edge) state_d = S_PAUSE;
        end
        S_PAUSE: begin
          // Prescaler holds so resuming keeps the sub-second phase
          if (start_edge) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control and count state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign running   = (state_q == S_RUN);
  assign sec_pulse = pulse_q;

`ifdef LAP_HOLD_EN
  logic        hold_q, hold_d;
  logic [15:0] snap_q, snap_d;

  // Lap toggles the display hold, only while running
  always_comb begin
    hold_d = hold_q;
    snap_d = snap_q;
    if (clr_edge) begin
      hold_d = 1'b0;
    end else if (btn_edge[2] && (state_q == S_RUN)) begin
      if (!hold_q) begin
        hold_d = 1'b1;
        snap_d = cnt_q;
      end else begin
        hold_d = 1'b0;
      end
    end
  end

  // Hold flag and snapshot registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= 1'b0;
      snap_q <= '0;
    end else begin
      hold_q <= hold_d;
      snap_q <= snap_d;
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = hold_q ? snap_q : cnt_q;
`else
  logic unused_lap_edge;
  assign unused_lap_edge = btn_edge[2];
  assign {min_tens, min_ones, sec_tens, sec_ones} = cnt_q;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter_cgrundey.sv
// Directed bench for stopwatch_bcd_counter_cgrundey at TICKS_PER_SEC=4.
module tb_stopwatch_bcd_counter_cgrundey;

  logic       clk;
  logic       rst;
  logic       start_stop;
  logic       clear;
  logic       lap;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running;
  logic       sec_pulse;
  logic [15:0] disp;

  int total = 0;
  int bad   = 0;

  stopwatch_bcd_counter_cgrundey #(
    .TICKS_PER_SEC(4),
    .TICK_W(3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_stop (start_stop),
    .clear      (clear),
    .lap        (lap),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .running    (running),
    .sec_pulse  (sec_pulse)
  );

  assign disp = {min_tens, min_ones, sec_tens, sec_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One-cycle button press; returns right after the edge that acts on it
  task automatic press(input logic s, input logic c, input logic l);
    start_stop = s; clear = c; lap = l;
    step();
    start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    step();
    step();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  int npulse;
  int last;
  int flag;
  logic [15:0] expd;

  initial begin
    rst = 1'b1; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    steps(2);
    check("rst_disp", {16'h0, disp}, 32'h0);
    check("rst_running", {31'h0, running}, 32'h0);
    check("rst_pulse", {31'h0, sec_pulse}, 32'h0);
    rst = 1'b0;
    steps(3);
    check("idle_disp", {16'h0, disp}, 32'h0);
    check("idle_running", {31'h0, running}, 32'h0);

    // Count: ten strobes, 4 cycles apart, ending on 00:10
    press(1'b1, 1'b0, 1'b0);
    check("start_running", {31'h0, running}, 32'h1);
    npulse = 0; last = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (sec_pulse === 1'b1) begin
        npulse++;
        check("pulse_gap", i - last, 4);
        last = i;
      end
    end
    check("count_pulses", npulse, 10);
    check("count_disp", {16'h0, disp}, 32'h0010);
    check("count_running", {31'h0, running}, 32'h1);

    press(1'b0, 1'b1, 1'b0);
    check("clear_disp", {16'h0, disp}, 32'h0);
    check("clear_running", {31'h0, running}, 32'h0);

    // Asynchronous reset mid-count at 00:07
    press(1'b1, 1'b0, 1'b0);
    steps(28);
    check("pre_rst_disp", {16'h0, disp}, 32'h0007);
    check("pre_rst_pulse", {31'h0, sec_pulse}, 32'h1);
    rst = 1'b1;
    #1;
    check("async_rst_disp", {16'h0, disp}, 32'h0);
    check("async_rst_running", {31'h0, running}, 32'h0);
    check("async_rst_pulse", {31'h0, sec_pulse}, 32'h0);
    #2;
    rst = 1'b0;
    steps(6);
    check("post_rst_running", {31'h0, running}, 32'h0);
    check("post_rst_disp", {16'h0, disp}, 32'h0);

    // Pause with prescaler held at 2, then resume
    press(1'b1, 1'b0, 1'b0);
    steps(3);
    press(1'b1, 1'b0, 1'b0);
    check("pause_running", {31'h0, running}, 32'h0);
    check("pause_disp", {16'h0, disp}, 32'h0001);
    flag = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (disp !== 16'h0001 || sec_pulse !== 1'b0 || running !== 1'b0) flag++;
    end
    check("pause_hold", flag, 0);
    press(1'b1, 1'b0, 1'b0);
    check("resume_running", {31'h0, running}, 32'h1);
    step();
    check("resume_pulse1", {31'h0, sec_pulse}, 32'h0);
    step();
    check("resume_pulse2", {31'h0, sec_pulse}, 32'h1);
    check("resume_disp", {16'h0, disp}, 32'h0002);

    // Clear and start in the same cycle while running at 00:03
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    steps(12);
    check("prio_pre_disp", {16'h0, disp}, 32'h0003);
    press(1'b1, 1'b1, 1'b0);
    check("prio_disp", {16'h0, disp}, 32'h0);
    check("prio_running", {31'h0, running}, 32'h0);
    steps(8);
    check("prio_stay_disp", {16'h0, disp}, 32'h0);
    check("prio_stay_running", {31'h0, running}, 32'h0);

    // Lap hold at 00:05, release at 00:08
    press(1'b1, 1'b0, 1'b0);
    steps(18);
    press(1'b0, 1'b0, 1'b1);
    check("lap_set_disp", {16'h0, disp}, 32'h0005);
    steps(9);
    lap = 1'b1;
    step();
    lap = 1'b0;
    step();
`ifdef LAP_HOLD_EN
    expd = 16'h0005;
`else
    expd = 16'h0008;
`endif
    check("lap_held_disp", {16'h0, disp}, {16'h0, expd});
    check("lap_live_pulse", {31'h0, sec_pulse}, 32'h1);
    step();
    check("lap_release_disp", {16'h0, disp}, 32'h0008);
    check("lap_running", {31'h0, running}, 32'h1);

    // Full run to 59:59 and wrap
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    npulse = 0; flag = 0;
    for (int i = 0; i < 14396; i++) begin
      step();
      if (sec_pulse === 1'b1) npulse++;
      if (sec_ones > 4'd9 || sec_tens > 4'd5 || min_ones > 4'd9 || min_tens > 4'd5) flag++;
    end
    check("wrap_range", flag, 0);
    check("wrap_pulses", npulse, 3599);
    check("wrap_pre_disp", {16'h0, disp}, 32'h5959);
    steps(3);
    check("wrap_no_early_pulse", {31'h0, sec_pulse}, 32'h0);
    step();
    check("wrap_disp", {16'h0, disp}, 32'h0000);
    check("wrap_pulse", {31'h0, sec_pulse}, 32'h1);
    check("wrap_running", {31'h0, running}, 32'h1);
    step();
    check("wrap_pulse_low", {31'h0, sec_pulse}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
